// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch history table predictor.
// Helpers work at a fixed maximum width; callers size-cast to their own widths.
package bp_pkg;

  localparam int CTR_W          = 16;
  localparam int IDX_W          = 16;
  localparam int CTR_BITS_DFLT  = 2;
  localparam int CTR_MAX        = (1 << CTR_BITS_DFLT) - 1;
  localparam int CTR_INIT       = CTR_MAX;

  // Saturating step: never wraps past max or below zero.
  function automatic logic [CTR_W-1:0] ctr_next(
    input logic [CTR_W-1:0] ctr,
    input logic             taken,
    input logic [CTR_W-1:0] max
  );
    if (taken) return (ctr == max)      ? ctr : ctr + 16'd1;
    else       return (ctr == 16'd0)    ? ctr : ctr - 16'd1;
  endfunction

  function automatic logic [IDX_W-1:0] bht_index(
    input logic [IDX_W-1:0] pc_idx,
    input logic [IDX_W-1:0] ghr,
    input logic             gshare
  );
    return gshare ? (pc_idx ^ ghr) : pc_idx;
  endfunction

endpackage

// File: rtl/bht_predictor_sat_counter.sv
// One BHT entry: CTR_BITS-wide saturating counter, reset to strong taken.
module sat_counter
  import bp_pkg::*;
#(
  parameter int CTR_BITS = 2
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_en,
  input  logic                i_taken,
  output logic [CTR_BITS-1:0] o_ctr
);

  localparam logic [CTR_BITS-1:0] MAX = '1;

  logic [CTR_BITS-1:0] r_ctr;
  logic [CTR_BITS-1:0] w_next;

  assign w_next = CTR_BITS'(ctr_next(CTR_W'(r_ctr), i_taken, CTR_W'(MAX)));

  always_ff @(posedge i_clk) begin
    if (i_rst)     r_ctr <= MAX;
    else if (i_en) r_ctr <= w_next;
  end

  assign o_ctr = r_ctr;

endmodule

// File: rtl/bht_predictor.sv
// Branch history table: per-entry saturating counters with optional gshare
// indexing; 1-cycle registered prediction, one training update per cycle.
module bht_predictor
  import bp_pkg::*;
#(
  parameter int INDEX_BITS = 4,
  parameter int CTR_BITS   = 2,
  parameter int PC_BITS    = 32,
  parameter int PC_SHIFT   = 2,
  parameter int GSHARE     = 0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_request,
  input  logic [PC_BITS-1:0]    i_req_pc,
  output logic                  o_prediction,
  output logic                  o_pred_valid,
  output logic [INDEX_BITS-1:0] o_pred_index,
  input  logic                  i_result,
  input  logic [INDEX_BITS-1:0] i_res_index,
  input  logic                  i_taken
);

  localparam int ENTRIES = 1 << INDEX_BITS;

  logic [ENTRIES-1:0][CTR_BITS-1:0] w_ctr;
  logic [INDEX_BITS-1:0]            w_pc_idx;
  logic [INDEX_BITS-1:0]            w_idx;
  logic [INDEX_BITS-1:0]            w_ghr_next;
  logic [INDEX_BITS-1:0]            r_ghr;
  logic                             r_prediction;
  logic                             r_pred_valid;
  logic [INDEX_BITS-1:0]            r_pred_index;

  assign w_pc_idx = i_req_pc[PC_SHIFT +: INDEX_BITS];
  assign w_idx    = INDEX_BITS'(bht_index(IDX_W'(w_pc_idx), IDX_W'(r_ghr), GSHARE != 0));

  for (genvar g = 0; g < ENTRIES; g++) begin : g_ent
    sat_counter #(.CTR_BITS(CTR_BITS)) u_ctr (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_en    (i_result && (i_res_index == INDEX_BITS'(g))),
      .i_taken (i_taken),
      .o_ctr   (w_ctr[g])
    );
  end

  if (INDEX_BITS == 1) begin : g_ghr1
    assign w_ghr_next = i_taken;
  end else begin : g_ghrn
    assign w_ghr_next = {r_ghr[INDEX_BITS-2:0], i_taken};
  end

  // History only moves in gshare mode; otherwise it stays zero.
  always_ff @(posedge i_clk) begin
    if (i_rst)                        r_ghr <= '0;
    else if (i_result && GSHARE != 0) r_ghr <= w_ghr_next;
  end

  // Read uses the pre-update counter: no bypass from a same-cycle train.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_prediction <= 1'b1;
      r_pred_valid <= 1'b0;
      r_pred_index <= '0;
    end else begin
      r_pred_valid <= i_request;
      if (i_request) begin
        r_prediction <= w_ctr[w_idx][CTR_BITS-1];
        r_pred_index <= w_idx;
      end
    end
  end

  assign o_prediction = r_prediction;
  assign o_pred_valid = r_pred_valid;
  assign o_pred_index = r_pred_index;

endmodule

// File: tb/tb_bht_predictor.sv
// Randomized + directed bench for bht_predictor: a plain-mode and a gshare
// instance share stimulus and are compared with an integer table model.
module tb_bht_predictor;

  logic        clk = 1'b0;
  logic        rst, request, result, taken;
  logic [31:0] req_pc;
  logic [3:0]  res_index;
  logic        pred0, pv0, pred1, pv1;
  logic [3:0]  pi0, pi1;

  int n_chk = 0;
  int n_err = 0;

  int m_ctr [2][16];
  int m_ghr;
  int m_pred [2];
  int m_pv [2];
  int m_pi [2];

  always #5 clk = ~clk;

  bht_predictor #(.INDEX_BITS(4), .CTR_BITS(2), .PC_BITS(32), .PC_SHIFT(2), .GSHARE(0)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_request(request), .i_req_pc(req_pc),
    .o_prediction(pred0), .o_pred_valid(pv0), .o_pred_index(pi0),
    .i_result(result), .i_res_index(res_index), .i_taken(taken));

  bht_predictor #(.INDEX_BITS(4), .CTR_BITS(2), .PC_BITS(32), .PC_SHIFT(2), .GSHARE(1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_request(request), .i_req_pc(req_pc),
    .o_prediction(pred1), .o_pred_valid(pv1), .o_pred_index(pi1),
    .i_result(result), .i_res_index(res_index), .i_taken(taken));

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: what each table does on this edge, from the behavioural rules.
  task automatic model_edge;
    int pc_idx, idx;
    if (rst) begin
      for (int g = 0; g < 2; g++) begin
        for (int e = 0; e < 16; e++) m_ctr[g][e] = 3;
        m_pred[g] = 1; m_pv[g] = 0; m_pi[g] = 0;
      end
      m_ghr = 0;
      return;
    end
    pc_idx = (req_pc / 4) % 16;
    for (int g = 0; g < 2; g++) begin
      m_pv[g] = request;
      if (request) begin
        idx = (g == 1) ? (pc_idx ^ m_ghr) : pc_idx;
        m_pred[g] = (m_ctr[g][idx] >= 2) ? 1 : 0;
        m_pi[g] = idx;
      end
      if (result) begin
        if (taken) m_ctr[g][res_index] = (m_ctr[g][res_index] < 3) ? m_ctr[g][res_index] + 1 : 3;
        else       m_ctr[g][res_index] = (m_ctr[g][res_index] > 0) ? m_ctr[g][res_index] - 1 : 0;
      end
    end
    if (result) m_ghr = (m_ghr * 2 + int'(taken)) % 16;
  endtask

  task automatic cyc(input logic r, input logic rq, input logic [31:0] pc,
                     input logic rs, input logic [3:0] ri, input logic tk);
    rst = r; request = rq; req_pc = pc; result = rs; res_index = ri; taken = tk;
    model_edge();
    @(posedge clk);
    #1;
    chk("pv0",   int'(pv0),   m_pv[0]);
    chk("pred0", int'(pred0), m_pred[0]);
    chk("pi0",   int'(pi0),   m_pi[0]);
    chk("pv1",   int'(pv1),   m_pv[1]);
    chk("pred1", int'(pred1), m_pred[1]);
    chk("pi1",   int'(pi1),   m_pi[1]);
  endtask

  initial begin
    rst = 1'b1; request = 1'b0; req_pc = '0; result = 1'b0; res_index = '0; taken = 1'b0;
    @(posedge clk); #1;
    cyc(1, 0, 0, 0, 0, 0);
    chk("rst_pred", int'(pred0), 1);
    chk("rst_pv",   int'(pv0),   0);
    chk("rst_pi",   int'(pi0),   0);

    // Cold request at pc 0x10 -> index 4, strong taken
    cyc(0, 1, 32'h10, 0, 0, 0);
    chk("t1_pred", int'(pred0), 1);
    chk("t1_pv",   int'(pv0),   1);
    chk("t1_pi",   int'(pi0),   4);

    // Four not-taken on index 4: 3->2->1->0, then stays 0
    for (int k = 0; k < 4; k++) cyc(0, 0, 0, 1, 4, 0);
    chk("t2_hold_pv", int'(pv0), 0);
    cyc(0, 1, 32'h10, 0, 0, 0);
    chk("t2_pred", int'(pred0), 0);

    // Two taken: 0->1 (still not taken), 1->2 (flips)
    cyc(0, 0, 0, 1, 4, 1);
    cyc(0, 1, 32'h10, 0, 0, 0);
    chk("t3_pred_ctr1", int'(pred0), 0);
    cyc(0, 0, 0, 1, 4, 1);
    cyc(0, 1, 32'h10, 0, 0, 0);
    chk("t3_pred_ctr2", int'(pred0), 1);

    // Same-cycle request + not-taken train on index 4 from 2: old value seen
    cyc(0, 1, 32'h10, 1, 4, 0);
    chk("t4_old", int'(pred0), 1);
    cyc(0, 1, 32'h10, 0, 0, 0);
    chk("t4_new", int'(pred0), 0);

    // Saturation at 3 after repeated taken
    for (int k = 0; k < 5; k++) cyc(0, 0, 0, 1, 4, 1);
    chk("t3_sat", m_ctr[0][4], 3);
    for (int k = 0; k < 2; k++) cyc(0, 0, 0, 1, 4, 0);
    cyc(0, 1, 32'h10, 0, 0, 0);
    chk("t3_sat_pred", int'(pred0), 0);

    // Gshare: history T,T,N,T -> 4'b1101, pc 0x10 -> index 9
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 1);
    cyc(0, 0, 0, 1, 0, 1);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 0, 1);
    cyc(0, 1, 32'h10, 0, 0, 0);
    chk("t5_pi_gshare", int'(pi1), 9);
    chk("t5_pi_plain",  int'(pi0), 4);

    // Reset colliding with a train: update dropped, table back to 3
    for (int k = 0; k < 3; k++) cyc(0, 0, 0, 1, 7, 0);
    cyc(1, 1, 32'h1c, 1, 7, 0);
    chk("t6_pv", int'(pv0), 0);
    cyc(0, 1, 32'h1c, 0, 0, 0);
    chk("t6_pred", int'(pred0), 1);
    chk("t6_pi1",  int'(pi1),   7);

    // Random traffic
    for (int k = 0; k < 400; k++)
      cyc(($urandom_range(0, 49) == 0), $urandom_range(0, 1), $urandom,
          $urandom_range(0, 1), 4'($urandom_range(0, 15)), $urandom_range(0, 1));

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
